sobel_edge: RTL

SOBEL_EDGE -- requirements
Module: sobel_edge

---
 rtl/sobel_edge.sv | 119 +++++++++++
 1 files changed

// File: rtl/sobel_edge.sv
`default_nettype none
// ============================================================================
// Module   : sobel_edge
// Purpose  : 3-stage Sobel edge detector over a 3x3 RGB window.
// Revision : 1.0 - initial release
// ============================================================================
module sobel_edge #(
  parameter int p_bit_width_in = 30,
  parameter int p_width        = 640,
  parameter int p_height       = 480
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clken,
  input  logic                        iSof,
  input  logic [9*p_bit_width_in-1:0] iGrid,
  input  logic [p_bit_width_in-1:0]   iPixel,
  input  logic [12:0]                 iThreshold,
  input  logic [p_bit_width_in-1:0]   iEdgeColor,
  output logic [p_bit_width_in-1:0]   oPixel,
  output logic                        oEdge,
  output logic                        oValid
);

  localparam int c_cw   = p_bit_width_in / 3;
  localparam int c_gw   = c_cw + 3;
  localparam int c_cmpw = (c_gw > 13) ? c_gw : 13;
  localparam int c_xw   = (p_width  > 1) ? $clog2(p_width)  : 1;
  localparam int c_yw   = (p_height > 1) ? $clog2(p_height) : 1;

  function automatic logic signed [c_gw-1:0] ext(input logic [c_cw-1:0] v);
    return $signed({3'b000, v});
  endfunction

  // Position tracking: iSof forces the current sample to (0,0).
  logic [c_xw-1:0] r_x, w_pos_x, w_nxt_x;
  logic [c_yw-1:0] r_y, w_pos_y, w_nxt_y;
  logic            w_border;

  always_comb begin
    w_pos_x = iSof ? '0 : r_x;
    w_pos_y = iSof ? '0 : r_y;
    w_nxt_x = w_pos_x + 1'b1;
    w_nxt_y = w_pos_y;
    if (w_pos_x == c_xw'(p_width - 1)) begin
      w_nxt_x = '0;
      w_nxt_y = (w_pos_y == c_yw'(p_height - 1)) ? '0 : w_pos_y + 1'b1;
    end
    w_border = (int'(w_pos_x) < 2) || (int'(w_pos_y) < 2);
  end

  // Per-tap intensity (R + 2G + B) >> 2.
  logic [c_cw-1:0] w_int [9];

  for (genvar k = 0; k < 9; k++) begin : g_tap
    logic [c_cw-1:0] w_r, w_g, w_b;
    logic [c_cw+1:0] w_sum;
    assign w_r      = iGrid[k*p_bit_width_in + 3*c_cw - 1 -: c_cw];
    assign w_g      = iGrid[k*p_bit_width_in + 2*c_cw - 1 -: c_cw];
    assign w_b      = iGrid[k*p_bit_width_in + c_cw - 1 -: c_cw];
    assign w_sum    = {2'b00, w_r} + {1'b0, w_g, 1'b0} + {2'b00, w_b};
    assign w_int[k] = c_cw'(w_sum >> 2);
  end

  logic [c_cw-1:0]           r_s1_int [9];
  logic [p_bit_width_in-1:0] r_s1_pix, r_s2_pix;
  logic                      r_s1_border, r_s2_border;
  logic                      r_s1_valid, r_s2_valid;
  logic signed [c_gw-1:0]    r_s2_gx, r_s2_gy, w_gx, w_gy;
  logic [c_gw-1:0]           w_abs_x, w_abs_y, w_mag;
  logic                      w_edge;

  always_comb begin
    w_gx = (ext(r_s1_int[2]) + ext(r_s1_int[5]) + ext(r_s1_int[5]) + ext(r_s1_int[8]))
         - (ext(r_s1_int[0]) + ext(r_s1_int[3]) + ext(r_s1_int[3]) + ext(r_s1_int[6]));
    w_gy = (ext(r_s1_int[6]) + ext(r_s1_int[7]) + ext(r_s1_int[7]) + ext(r_s1_int[8]))
         - (ext(r_s1_int[0]) + ext(r_s1_int[1]) + ext(r_s1_int[1]) + ext(r_s1_int[2]));
    w_abs_x = r_s2_gx[c_gw-1] ? c_gw'(-r_s2_gx) : c_gw'(r_s2_gx);
    w_abs_y = r_s2_gy[c_gw-1] ? c_gw'(-r_s2_gy) : c_gw'(r_s2_gy);
    w_mag   = w_abs_x + w_abs_y;
    w_edge  = (c_cmpw'(w_mag) > c_cmpw'(iThreshold)) && !r_s2_border;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_x         <= '0;
      r_y         <= '0;
      for (int k = 0; k < 9; k++) r_s1_int[k] <= '0;
      r_s1_pix    <= '0;
      r_s1_border <= 1'b0;
      r_s1_valid  <= 1'b0;
      r_s2_gx     <= '0;
      r_s2_gy     <= '0;
      r_s2_pix    <= '0;
      r_s2_border <= 1'b0;
      r_s2_valid  <= 1'b0;
      oPixel      <= '0;
      oEdge       <= 1'b0;
      oValid      <= 1'b0;
    end else if (clken) begin
      r_x         <= w_nxt_x;
      r_y         <= w_nxt_y;
      for (int k = 0; k < 9; k++) r_s1_int[k] <= w_int[k];
      r_s1_pix    <= iPixel;
      r_s1_border <= w_border;
      r_s1_valid  <= 1'b1;
      r_s2_gx     <= w_gx;
      r_s2_gy     <= w_gy;
      r_s2_pix    <= r_s1_pix;
      r_s2_border <= r_s1_border;
      r_s2_valid  <= r_s1_valid;
      oPixel      <= w_edge ? iEdgeColor : r_s2_pix;
      oEdge       <= w_edge;
      oValid      <= r_s2_valid;
    end
  end

endmodule
`default_nettype wire
